// File: rtl/ts_ctrl.sv
// rtl/ts_ctrl.sv - TurboSound bus decode, chip-select command capture and AY clock divider
module ts_ctrl #(
  parameter int NUM_CHIPS = 2,
  parameter int CLK_DIV   = 2
) (
  input  logic                 clk350,
  input  logic                 reset,
  input  logic                 a1,
  input  logic                 a14,
  input  logic                 a15,
  input  logic                 m1,
  input  logic                 iorq,
  input  logic                 wr,
  input  logic [7:0]           d,
  output logic                 bc1,
  output logic                 bdir,
  output logic [NUM_CHIPS-1:0] cs_n,
  output logic                 clk_ay,
  output logic [1:0]           sel
);

  // Chip 0 is selected out of reset.
  localparam logic [NUM_CHIPS-1:0] CS_RST   = ~NUM_CHIPS'(1);
  localparam logic [4:0]           DIV_LAST = 5'(CLK_DIV - 1);
  localparam logic [4:0]           DIV_HALF = 5'(CLK_DIV / 2);

  logic                 ssg;
  logic                 bc1_raw;
  logic                 bdir_raw;
  logic                 addr_wr;
  logic                 cmd_byte;
  logic                 cmd_hit;
  logic                 capture;
  logic [1:0]           idx;
  logic                 idx_ok;
  logic [NUM_CHIPS-1:0] cs_d;
  logic [4:0]           cnt_d;

  logic                 cmd_hit_q;
  logic                 run_q;
  logic [4:0]           cnt_q;
  logic                 clk_ay_q;
  logic [NUM_CHIPS-1:0] cs_n_q;
  logic [1:0]           sel_q;

  // Raw port decode and command-byte detection.
  always_comb begin
    ssg      = a15 & ~a1 & ~iorq;
    bc1_raw  = ssg & a14 & m1;
    bdir_raw = ssg & ~wr;
    addr_wr  = bc1_raw & bdir_raw;
    cmd_byte = (d[7:3] == 5'b11111);
    cmd_hit  = addr_wr & cmd_byte;
    capture  = cmd_hit & ~cmd_hit_q;
    idx      = ~d[1:0];
    idx_ok   = ({1'b0, idx} < 3'(NUM_CHIPS));
  end

  // Command bytes never reach the chips; everything else passes straight through.
  always_comb begin
    bc1  = bc1_raw & ~cmd_hit;
    bdir = bdir_raw & ~cmd_hit;
  end

  // One-hot active-low select for the commanded chip.
  always_comb begin
    cs_d = '1;
    for (int i = 0; i < NUM_CHIPS; i++) begin
      cs_d[i] = (idx != 2'(i));
    end
  end

  // Divider next count, wrapping at CLK_DIV-1.
  always_comb begin
    cnt_d = (cnt_q == DIV_LAST) ? 5'd0 : cnt_q + 5'd1;
  end

  // Edge-detected command capture; out-of-range chip indices are ignored entirely.
  always_ff @(posedge clk350 or negedge reset) begin
    if (!reset) begin
      cmd_hit_q <= 1'b0;
      cs_n_q    <= CS_RST;
      sel_q     <= 2'd0;
      run_q     <= 1'b1;
    end else begin
      cmd_hit_q <= cmd_hit;
      if (capture && idx_ok) begin
        cs_n_q <= cs_d;
        sel_q  <= idx;
        run_q  <= d[2];
      end
    end
  end

  // AY clock divider; halting parks the count at 0 so a restart begins a fresh low half.
  always_ff @(posedge clk350 or negedge reset) begin
    if (!reset) begin
      cnt_q    <= 5'd0;
      clk_ay_q <= 1'b0;
    end else if (run_q) begin
      cnt_q    <= cnt_d;
      clk_ay_q <= (cnt_d >= DIV_HALF);
    end else begin
      cnt_q    <= 5'd0;
      clk_ay_q <= 1'b0;
    end
  end

  assign cs_n   = cs_n_q;
  assign sel    = sel_q;
  assign clk_ay = clk_ay_q;

endmodule

// File: tb/tb_ts_ctrl.sv
// tb/tb_ts_ctrl.sv - directed bench for ts_ctrl across three parameter sets
module tb_ts_ctrl;

  logic       clk350;
  logic       reset;
  logic       a1, a14, a15, m1, iorq, wr;
  logic [7:0] d;

  logic       bc1_a, bdir_a, clk_a;
  logic [1:0] cs_a, sel_a;
  logic       bc1_b, bdir_b, clk_b;
  logic [3:0] cs_b;
  logic [1:0] sel_b;
  logic       bc1_c, bdir_c, clk_c;
  logic [0:0] cs_c;
  logic [1:0] sel_c;

  int checks   = 0;
  int failures = 0;
  bit check_en = 0;

  ts_ctrl #(.NUM_CHIPS(2), .CLK_DIV(2)) u_a (
    .clk350(clk350), .reset(reset), .a1(a1), .a14(a14), .a15(a15), .m1(m1),
    .iorq(iorq), .wr(wr), .d(d), .bc1(bc1_a), .bdir(bdir_a), .cs_n(cs_a),
    .clk_ay(clk_a), .sel(sel_a)
  );

  ts_ctrl #(.NUM_CHIPS(4), .CLK_DIV(4)) u_b (
    .clk350(clk350), .reset(reset), .a1(a1), .a14(a14), .a15(a15), .m1(m1),
    .iorq(iorq), .wr(wr), .d(d), .bc1(bc1_b), .bdir(bdir_b), .cs_n(cs_b),
    .clk_ay(clk_b), .sel(sel_b)
  );

  ts_ctrl #(.NUM_CHIPS(1), .CLK_DIV(2)) u_c (
    .clk350(clk350), .reset(reset), .a1(a1), .a14(a14), .a15(a15), .m1(m1),
    .iorq(iorq), .wr(wr), .d(d), .bc1(bc1_c), .bdir(bdir_c), .cs_n(cs_c),
    .clk_ay(clk_c), .sel(sel_c)
  );

  initial clk350 = 1'b0;
  always #5 clk350 = ~clk350;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: per-instance selected chip, run flag, edges since the
  // divider started, and the last command-strobe level.
  int NCH [3] = '{2, 4, 1};
  int DIV [3] = '{2, 4, 2};
  int m_sel   [3];
  int m_run   [3];
  int m_prev  [3];
  int m_phase [3];
  int m_clk   [3];

  function automatic logic is_cmd_write();
    logic selected, ffd_latch, writing;
    selected  = a15 && !a1 && !iorq;
    ffd_latch = selected && a14 && m1;
    writing   = selected && !wr;
    return ffd_latch && writing && (d >= 8'hF8);
  endfunction

  function automatic logic [1:0] exp_bus();
    logic selected;
    selected = a15 && !a1 && !iorq;
    if (is_cmd_write()) return 2'b00;
    return {selected && a14 && m1, selected && !wr};
  endfunction

  initial begin
    forever begin
      @(posedge clk350);
      for (int k = 0; k < 3; k++) begin
        if (!reset) begin
          m_sel[k] = 0; m_run[k] = 1; m_prev[k] = 0; m_phase[k] = 0; m_clk[k] = 0;
        end else begin
          int hit, chip;
          hit = is_cmd_write() ? 1 : 0;
          if (m_run[k] != 0) begin
            m_phase[k] = m_phase[k] + 1;
            m_clk[k]   = ((m_phase[k] % DIV[k]) >= DIV[k] / 2) ? 1 : 0;
          end else begin
            m_phase[k] = 0;
            m_clk[k]   = 0;
          end
          if (hit == 1 && m_prev[k] == 0) begin
            chip = 3 - int'(d[1:0]);
            if (chip < NCH[k]) begin
              m_sel[k] = chip;
              m_run[k] = int'(d[2]);
            end
          end
          m_prev[k] = hit;
        end
      end
    end
  end

  // Compare every instance against the model on each falling edge.
  initial begin
    forever begin
      @(negedge clk350);
      if (check_en) begin
        for (int k = 0; k < 3; k++) begin
          logic [3:0] act_cs, exp_cs;
          logic [1:0] act_sel, act_bus;
          logic       act_clk;
          case (k)
            0: begin act_cs = {2'b11, cs_a};  act_sel = sel_a; act_clk = clk_a; act_bus = {bc1_a, bdir_a}; end
            1: begin act_cs = cs_b;           act_sel = sel_b; act_clk = clk_b; act_bus = {bc1_b, bdir_b}; end
            default: begin act_cs = {3'b111, cs_c}; act_sel = sel_c; act_clk = clk_c; act_bus = {bc1_c, bdir_c}; end
          endcase
          exp_cs = 4'b1111;
          exp_cs[m_sel[k]] = 1'b0;
          chk($sformatf("model_bus%0d", k), {6'd0, act_bus}, {6'd0, exp_bus()});
          chk($sformatf("model_cs%0d", k),  {4'd0, act_cs},  {4'd0, exp_cs});
          chk($sformatf("model_sel%0d", k), {6'd0, act_sel}, 8'(m_sel[k]));
          chk($sformatf("model_clk%0d", k), {7'd0, act_clk}, 8'(m_clk[k]));
        end
      end
    end
  end

  task automatic idle();
    a15 = 1'b0; a14 = 1'b0; a1 = 1'b1; m1 = 1'b1; iorq = 1'b1; wr = 1'b1; d = 8'h00;
    #1;
  endtask

  task automatic bus(input logic a14v, input logic wrv, input logic [7:0] dv);
    a15 = 1'b1; a14 = a14v; a1 = 1'b0; m1 = 1'b1; iorq = 1'b0; wr = wrv; d = dv;
    #1;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk350);
    #2;
  endtask

  logic [7:0] pat;

  initial begin
    reset = 1'b0;
    idle();
    step(3);
    check_en = 1;
    chk("rst_cs_b", {4'd0, cs_b}, 8'h0E);
    chk("rst_clk_a", {7'd0, clk_a}, 8'h00);
    reset = 1'b1;
    step(1);
    chk("rel_clk_hi", {7'd0, clk_a}, 8'h01);
    chk("rel_cs_a", {6'd0, cs_a}, 8'h02);
    chk("rel_sel_a", {6'd0, sel_a}, 8'h00);
    chk("rel_bus", {6'd0, bc1_a, bdir_a}, 8'h00);
    step(1);
    chk("rel_clk_lo", {7'd0, clk_a}, 8'h00);

    // 0xFE held three cycles, data changing mid-strobe
    bus(1'b1, 1'b0, 8'hFE);
    chk("fe_suppr", {6'd0, bc1_a, bdir_a}, 8'h00);
    step(1);
    chk("fe_sel_a", {6'd0, sel_a}, 8'h01);
    chk("fe_cs_a", {6'd0, cs_a}, 8'h01);
    d = 8'hFF;
    #1;
    step(2);
    chk("fe_once", {6'd0, sel_a}, 8'h01);
    chk("fe_cs_c", {7'd0, cs_c}, 8'h00);
    idle();
    step(1);

    // Register select, data write and read pass through
    bus(1'b1, 1'b0, 8'h07);
    chk("latch_bus", {6'd0, bc1_a, bdir_a}, 8'h03);
    step(1);
    idle();
    step(1);
    bus(1'b0, 1'b0, 8'h3F);
    chk("data_bus", {6'd0, bc1_a, bdir_a}, 8'h01);
    step(1);
    idle();
    chk("data_cs_a", {6'd0, cs_a}, 8'h01);
    step(1);
    bus(1'b1, 1'b1, 8'hFF);
    chk("read_bus", {6'd0, bc1_b, bdir_b}, 8'h02);
    step(1);
    idle();
    step(1);

    // Out-of-range chip for the two-chip instance
    bus(1'b1, 1'b0, 8'hFC);
    chk("fc_suppr", {6'd0, bc1_a, bdir_a}, 8'h00);
    step(1);
    idle();
    chk("fc_sel_a", {6'd0, sel_a}, 8'h01);
    chk("fc_cs_a", {6'd0, cs_a}, 8'h01);
    chk("fc_sel_b", {6'd0, sel_b}, 8'h03);
    step(1);

    // Halt then restart the AY clock
    bus(1'b1, 1'b0, 8'hFB);
    step(1);
    idle();
    step(1);
    chk("halt_clk_b", {7'd0, clk_b}, 8'h00);
    chk("halt_clk_a", {7'd0, clk_a}, 8'h00);
    step(1);
    chk("halt_clk_b2", {7'd0, clk_b}, 8'h00);
    step(3);
    bus(1'b1, 1'b0, 8'hFF);
    step(1);
    idle();
    pat = 8'b01100110;
    for (int i = 0; i < 8; i++) begin
      step(1);
      chk($sformatf("run_clk_b%0d", i), {7'd0, clk_b}, {7'd0, pat[i]});
    end
    chk("run_sel_b", {6'd0, sel_b}, 8'h00);

    // Four-chip select, then reset in the middle of the next strobe
    bus(1'b1, 1'b0, 8'hFD);
    step(1);
    idle();
    chk("fd_sel_b", {6'd0, sel_b}, 8'h02);
    chk("fd_cs_b", {4'd0, cs_b}, 8'h0B);
    chk("fd_sel_a", {6'd0, sel_a}, 8'h00);
    step(1);
    bus(1'b1, 1'b0, 8'hFE);
    reset = 1'b0;
    #1;
    chk("mid_rst_cs_b", {4'd0, cs_b}, 8'h0E);
    chk("mid_rst_sel_b", {6'd0, sel_b}, 8'h00);
    chk("mid_rst_clk_b", {7'd0, clk_b}, 8'h00);
    step(2);
    reset = 1'b1;
    step(1);
    chk("post_rst_sel_b", {6'd0, sel_b}, 8'h01);
    chk("post_rst_cs_b", {4'd0, cs_b}, 8'h0D);
    idle();
    step(2);

    check_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
